// File: rtl/column_median3_filter.sv
// column_median3_filter: vertical 3-tap median over a column-major stream with edge replication and column/frame markers
module column_median3_filter #(
  parameter int width = 120,
  parameter int height = 240,
  parameter int data_width = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  filter_en,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_col_start,
  output logic                  out_frame_end
);
  localparam int rw = height > 1 ? $clog2(height) : 1;
  localparam int cw = width > 1 ? $clog2(width) : 1;
  logic [rw-1:0] in_row;
  logic [cw-1:0] in_col;
  logic [data_width-1:0] prev1, prev2, flush_data, a, lo, hi, m2, med;
  logic en1, flush_pending, flush_last, last_row, last_col;
  assign last_row = in_row == rw'(height - 1);
  assign last_col = in_col == cw'(width - 1);
  always_comb begin
    a = in_row == rw'(1) ? prev1 : prev2;
    lo = a < prev1 ? a : prev1;
    hi = a < prev1 ? prev1 : a;
    m2 = hi < in_data ? hi : in_data;
    med = lo > m2 ? lo : m2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      in_row <= '0;
      in_col <= '0;
      prev1 <= '0;
      prev2 <= '0;
      en1 <= 1'b0;
      flush_data <= '0;
      flush_pending <= 1'b0;
      flush_last <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_col_start <= 1'b0;
      out_frame_end <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_col_start <= 1'b0;
      out_frame_end <= 1'b0;
      flush_pending <= 1'b0;
      if (flush_pending) begin
        out_valid <= 1'b1;
        out_data <= flush_data;
        out_frame_end <= flush_last;
      end
      if (in_valid) begin
        prev2 <= prev1;
        prev1 <= in_data;
        en1 <= filter_en;
        in_row <= last_row ? '0 : in_row + 1'b1;
        if (last_row) in_col <= last_col ? '0 : in_col + 1'b1;
        if (in_row != '0) begin
          out_valid <= 1'b1;
          out_data <= en1 ? med : prev1;
          out_col_start <= in_row == rw'(1);
        end
        if (last_row) begin
          flush_pending <= 1'b1;
          flush_data <= in_data;
          flush_last <= last_col;
        end
      end
    end
  end
endmodule
